guess_collector: RTL and testbench
==================================

Name: guess_collector

Overview:
Upstream front-end for the 16-player closest-number correlator. Accepts player guesses one at a time over a valid/ready handshake and stores each guess in that player's slot. Latches the round's target number. When all 16 players have submitted, or a timeout expires, it presents the 16 numbers and the target in parallel, held stable, until the consumer acknowledges the round.

Parameters:
WIDTH, 32, bit width of each guess and of the target
TIMEOUT, 64, maximum cycles spent in COLLECT before the round is forced closed (must be at least 2)
FILL, all-ones of WIDTH, value placed in slots of players who did not submit

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Target_Valid  input  1  target strobe; starts a round when in IDLE
Target_In  input  WIDTH  target value, sampled with Target_Valid
In_Valid  input  1  guess valid
In_Ready  output  1  guess ready; high only in COLLECT
In_Player  input  4  player index 0..15; index 0 maps to Num_1, index 15 maps to Num_16
In_Num  input  WIDTH  guess value
Num_1 .. Num_16  output  WIDTH each  registered player slots feeding the correlator
Target_Num  output  WIDTH  registered target feeding the correlator
Round_Valid  output  1  high in PRESENT; all Num_* and Target_Num are stable while it is high
Round_Ack  input  1  consumer has finished the round; honoured only in PRESENT
Submitted_Mask  output  16  bit i set means player i has submitted this round
Dup_Error  output  1  one-cycle pulse when a duplicate guess is rejected
Timed_Out  output  1  round closed by timeout; held through PRESENT
Round_Count  output  8  number of completed rounds; wraps 255 to 0

Behaviour:
- Reset, applied synchronously on any clock edge and in any state, sets:
  - state to IDLE
  - all Num_* and Target_Num to 0
  - Submitted_Mask, Round_Count, Round_Valid, In_Ready, Dup_Error and Timed_Out to 0
  - the timer to 0
- IDLE:
  - In_Ready=0 and In_Valid is ignored.
  - When Target_Valid=1: Target_Num<=Target_In, all Num_*<=FILL, Submitted_Mask<=0, timer<=0, Timed_Out<=0, next state COLLECT.
- COLLECT:
  - In_Ready=1 and Target_Valid is ignored.
  - A transfer occurs when In_Valid and In_Ready are both high on the same edge.
  - If Submitted_Mask[In_Player]=0: the slot is written with In_Num and the mask bit is set, both visible the next cycle.
  - If the mask bit is already set: the slot is unchanged (first guess wins) and Dup_Error pulses high the next cycle.
  - The timer increments every COLLECT cycle.
  - Exit to PRESENT when the mask, including the current cycle's accept, becomes all-ones. The 16th accept therefore moves to PRESENT on the next cycle, with In_Ready low from that cycle onward.
  - Otherwise exit to PRESENT when the timer reaches TIMEOUT-1, and set Timed_Out=1. A valid transfer on that same cycle is still accepted.
  - If mask-full and timeout occur on the same cycle, mask-full wins and Timed_Out stays 0.
- PRESENT:
  - Round_Valid=1 and In_Ready=0; outputs are frozen.
  - On Round_Ack=1: Round_Count increments, next state IDLE, Round_Valid drops on the next cycle.
  - Round_Ack in any other state has no effect.
  - Target_Valid in PRESENT is ignored; the target is not queued.
- Unsubmitted slots keep FILL. Num_* keep their values after the round, until the next Target_Valid.
- All outputs are registered; there is no combinational path from inputs to outputs.
- In_Player is always a valid index (4 bits); no out-of-range handling is needed.

Test Plan:
- Reset then Target_Valid with Target_In=60; 16 accepts of players 0..15 with values 100,200,…,1600 -> 17 cycles after Target_Valid, Round_Valid=1, Num_1=100, Num_16=1600, Target_Num=60, Timed_Out=0, mask=16'hFFFF; Round_Ack -> Round_Count=1, IDLE.
- Target=30; only players 3 and 7 submit (80 and 70); wait TIMEOUT=64 cycles -> Round_Valid=1, Timed_Out=1, Num_4=80, Num_8=70, all other slots 32'hFFFFFFFF, mask=16'h0088.
- Player 5 sends 40 then 99 -> Num_6 stays 40; Dup_Error pulses exactly one cycle, aligned with the second accept.
- In_Valid held high in IDLE and PRESENT with new values -> no slot changes, In_Ready=0; Round_Ack pulsed in COLLECT -> ignored.
- Reset asserted mid-COLLECT with mask=16'h00FF -> next cycle state IDLE, mask=0, all Num_*=0, Round_Count unchanged-to-0.
- 256 full rounds -> Round_Count wraps to 0. The 16th accept lands on the cycle the timer reaches TIMEOUT-1 -> Timed_Out=0.

Source files
------------

// File: rtl/guess_collector.sv
// guess_collector: collects one guess per player for a 16-player round,
// latches the round target, and presents all numbers in parallel until the
// consumer acknowledges. A round closes when every player has submitted or
// when TIMEOUT cycles have been spent collecting.
module guess_collector #(
  parameter int               WIDTH   = 32,
  parameter int               TIMEOUT = 64,
  parameter logic [WIDTH-1:0] FILL    = '1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Target_Valid,
  input  logic [WIDTH-1:0] Target_In,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       In_Player,
  input  logic [WIDTH-1:0] In_Num,
  output logic [WIDTH-1:0] Num_1,
  output logic [WIDTH-1:0] Num_2,
  output logic [WIDTH-1:0] Num_3,
  output logic [WIDTH-1:0] Num_4,
  output logic [WIDTH-1:0] Num_5,
  output logic [WIDTH-1:0] Num_6,
  output logic [WIDTH-1:0] Num_7,
  output logic [WIDTH-1:0] Num_8,
  output logic [WIDTH-1:0] Num_9,
  output logic [WIDTH-1:0] Num_10,
  output logic [WIDTH-1:0] Num_11,
  output logic [WIDTH-1:0] Num_12,
  output logic [WIDTH-1:0] Num_13,
  output logic [WIDTH-1:0] Num_14,
  output logic [WIDTH-1:0] Num_15,
  output logic [WIDTH-1:0] Num_16,
  output logic [WIDTH-1:0] Target_Num,
  output logic             Round_Valid,
  input  logic             Round_Ack,
  output logic [15:0]      Submitted_Mask,
  output logic             Dup_Error,
  output logic             Timed_Out,
  output logic [7:0]       Round_Count
);

  localparam int             TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_num [16];
  logic [WIDTH-1:0] r_target;
  logic [15:0]      r_mask;
  logic [TW-1:0]    r_timer;
  logic [7:0]       r_count;
  logic             r_in_ready;
  logic             r_round_valid;
  logic             r_dup;
  logic             r_timed_out;

  logic             w_fire;
  logic             w_new;
  logic             w_dup;
  logic [15:0]      w_mask_next;
  logic             w_full;
  logic             w_tmo;

  // Handshake decode and round-closing conditions for the current cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    w_fire      = 1'b0;
    w_new       = 1'b0;
    w_dup       = 1'b0;
    w_mask_next = r_mask;
    w_full      = 1'b0;
    w_tmo       = 1'b0;
    if (r_state == S_COLLECT) begin
      w_fire      = In_Valid;
      w_new       = w_fire & ~r_mask[In_Player];
      w_dup       = w_fire &  r_mask[In_Player];
      w_mask_next = r_mask | (w_new ? (16'd1 << In_Player) : 16'd0);
      w_full      = &w_mask_next;
      w_tmo       = (r_timer == TMAX);
    end
  end

  // Next-state selection; mask-full takes priority over timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (Target_Valid)     w_state_next = S_COLLECT;
      S_COLLECT: if (w_full || w_tmo)  w_state_next = S_PRESENT;
      S_PRESENT: if (Round_Ack)        w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Round datapath: slots, target, mask, timer, status flags and counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      // NOTE: the slot array is cleared on reset because the consumer sees it directly on Num_* outputs.
      for (int i = 0; i < 16; i++) r_num[i] <= '0;
      r_target      <= '0;
      r_mask        <= '0;
      r_timer       <= '0;
      r_count       <= '0;
      r_in_ready    <= 1'b0;
      r_round_valid <= 1'b0;
      r_dup         <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      r_in_ready    <= (w_state_next == S_COLLECT);
      r_round_valid <= (w_state_next == S_PRESENT);
      r_dup         <= w_dup;
      case (r_state)
        S_IDLE: begin
          if (Target_Valid) begin
            r_target    <= Target_In;
            for (int i = 0; i < 16; i++) r_num[i] <= FILL;
            r_mask      <= '0;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
          end
        end
        S_COLLECT: begin
          r_timer <= r_timer + 1'b1;
          r_mask  <= w_mask_next;
          if (w_new) r_num[In_Player] <= In_Num;
          if (!w_full && w_tmo) r_timed_out <= 1'b1;
        end
        S_PRESENT: begin
          if (Round_Ack) r_count <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign In_Ready       = r_in_ready;
  assign Round_Valid    = r_round_valid;
  assign Dup_Error      = r_dup;
  assign Timed_Out      = r_timed_out;
  assign Submitted_Mask = r_mask;
  assign Round_Count    = r_count;
  assign Target_Num     = r_target;
  assign Num_1  = r_num[0];
  assign Num_2  = r_num[1];
  assign Num_3  = r_num[2];
  assign Num_4  = r_num[3];
  assign Num_5  = r_num[4];
  assign Num_6  = r_num[5];
  assign Num_7  = r_num[6];
  assign Num_8  = r_num[7];
  assign Num_9  = r_num[8];
  assign Num_10 = r_num[9];
  assign Num_11 = r_num[10];
  assign Num_12 = r_num[11];
  assign Num_13 = r_num[12];
  assign Num_14 = r_num[13];
  assign Num_15 = r_num[14];
  assign Num_16 = r_num[15];

endmodule

// File: tb/tb_guess_collector.sv
// Directed self-checking bench for guess_collector with default parameters.
module tb_guess_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        tgt_valid;
  logic [31:0] tgt_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_player;
  logic [31:0] in_num;
  logic [31:0] num [16];
  logic [31:0] tgt_num;
  logic        round_valid;
  logic        round_ack;
  logic [15:0] mask;
  logic        dup_error;
  logic        timed_out;
  logic [7:0]  round_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  guess_collector dut (
    .Clock(clk), .Reset(rst),
    .Target_Valid(tgt_valid), .Target_In(tgt_in),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_Player(in_player), .In_Num(in_num),
    .Num_1(num[0]),   .Num_2(num[1]),   .Num_3(num[2]),   .Num_4(num[3]),
    .Num_5(num[4]),   .Num_6(num[5]),   .Num_7(num[6]),   .Num_8(num[7]),
    .Num_9(num[8]),   .Num_10(num[9]),  .Num_11(num[10]), .Num_12(num[11]),
    .Num_13(num[12]), .Num_14(num[13]), .Num_15(num[14]), .Num_16(num[15]),
    .Target_Num(tgt_num), .Round_Valid(round_valid), .Round_Ack(round_ack),
    .Submitted_Mask(mask), .Dup_Error(dup_error), .Timed_Out(timed_out),
    .Round_Count(round_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [31:0] t);
    tgt_valid = 1'b1;
    tgt_in    = t;
    step();
    tgt_valid = 1'b0;
  endtask

  task automatic accept(input int p, input logic [31:0] v);
    in_valid  = 1'b1;
    in_player = 4'(p);
    in_num    = v;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic ack();
    round_ack = 1'b1;
    step();
    round_ack = 1'b0;
  endtask

  task automatic full_round(input logic [31:0] t);
    start_round(t);
    for (int p = 0; p < 16; p++) accept(p, 32'(p + 1));
    check("fr_round_valid", {31'd0, round_valid}, 32'd1);
    ack();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt_in = '0; in_valid = 1'b0;
    in_player = '0; in_num = '0; round_ack = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",    {31'd0, in_ready},    32'd0);
    check("rst_round_valid", {31'd0, round_valid}, 32'd0);
    check("rst_mask",        {16'd0, mask},        32'd0);
    check("rst_count",       {24'd0, round_count}, 32'd0);
    check("rst_num1",        num[0],               32'd0);
    check("rst_target",      tgt_num,              32'd0);
    check("rst_timed_out",   {31'd0, timed_out},   32'd0);

    // Round 1: all sixteen players submit in order.
    start_round(32'd60);
    check("r1_in_ready", {31'd0, in_ready}, 32'd1);
    check("r1_num1_fill", num[0], 32'hFFFF_FFFF);
    for (int p = 0; p < 16; p++) begin
      if (p == 15) begin
        check("r1_rv_before_last", {31'd0, round_valid}, 32'd0);
        check("r1_mask_before_last", {16'd0, mask}, 32'h7FFF);
      end
      accept(p, 32'((p + 1) * 100));
    end
    check("r1_round_valid", {31'd0, round_valid}, 32'd1);
    check("r1_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("r1_num1", num[0], 32'd100);
    check("r1_num16", num[15], 32'd1600);
    check("r1_target", tgt_num, 32'd60);
    check("r1_timed_out", {31'd0, timed_out}, 32'd0);
    check("r1_mask", {16'd0, mask}, 32'hFFFF);

    // PRESENT: guesses and a new target are ignored.
    in_valid = 1'b1; in_player = 4'd0; in_num = 32'd5;
    tgt_valid = 1'b1; tgt_in = 32'd999;
    step(); step(); step();
    tgt_valid = 1'b0;
    check("pr_num1_frozen", num[0], 32'd100);
    check("pr_target_frozen", tgt_num, 32'd60);
    check("pr_in_ready", {31'd0, in_ready}, 32'd0);
    check("pr_round_valid", {31'd0, round_valid}, 32'd1);
    in_valid = 1'b0;
    ack();
    check("r1_rv_dropped", {31'd0, round_valid}, 32'd0);
    check("r1_count", {24'd0, round_count}, 32'd1);

    // IDLE: guesses ignored, slots and mask retained.
    in_valid = 1'b1; in_player = 4'd15; in_num = 32'd7;
    step(); step();
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    check("idle_num16", num[15], 32'd1600);
    check("idle_mask", {16'd0, mask}, 32'hFFFF);
    in_valid = 1'b0;

    // Round 2: timeout with only players 3 and 7; an ack in COLLECT is ignored.
    start_round(32'd30);
    for (int k = 1; k <= 64; k++) begin
      case (k)
        1: begin in_valid = 1'b1; in_player = 4'd3; in_num = 32'd80; end
        2: begin in_valid = 1'b0; round_ack = 1'b1; end
        3: begin round_ack = 1'b0; in_valid = 1'b1; in_player = 4'd7; in_num = 32'd70; end
        default: in_valid = 1'b0;
      endcase
      step();
      if (k == 2) begin
        check("r2_ack_ignored_count", {24'd0, round_count}, 32'd1);
        check("r2_ack_ignored_ready", {31'd0, in_ready}, 32'd1);
      end
      if (k == 63) check("r2_rv_before_tmo", {31'd0, round_valid}, 32'd0);
    end
    in_valid = 1'b0; round_ack = 1'b0;
    check("r2_round_valid", {31'd0, round_valid}, 32'd1);
    check("r2_timed_out", {31'd0, timed_out}, 32'd1);
    check("r2_mask", {16'd0, mask}, 32'h0088);
    check("r2_target", tgt_num, 32'd30);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] e;
      e = (i == 3) ? 32'd80 : (i == 7) ? 32'd70 : 32'hFFFF_FFFF;
      check($sformatf("r2_num%0d", i + 1), num[i], e);
    end
    step();
    check("r2_timed_out_held", {31'd0, timed_out}, 32'd1);
    ack();
    check("r2_count", {24'd0, round_count}, 32'd2);

    // Round 3: duplicate guess from player 5, then reset mid-collect.
    start_round(32'd5);
    accept(5, 32'd40);
    check("dup_none_first", {31'd0, dup_error}, 32'd0);
    accept(5, 32'd99);
    check("dup_pulse", {31'd0, dup_error}, 32'd1);
    check("dup_first_wins", num[5], 32'd40);
    step();
    check("dup_one_cycle", {31'd0, dup_error}, 32'd0);
    for (int p = 0; p < 8; p++) if (p != 5) accept(p, 32'(p + 10));
    check("r3_mask", {16'd0, mask}, 32'h00FF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mrst_mask", {16'd0, mask}, 32'd0);
    check("mrst_num1", num[0], 32'd0);
    check("mrst_num6", num[5], 32'd0);
    check("mrst_target", tgt_num, 32'd0);
    check("mrst_count", {24'd0, round_count}, 32'd0);
    in_valid = 1'b1; in_player = 4'd9; in_num = 32'd1;
    step();
    in_valid = 1'b0;
    check("mrst_idle_ignores", num[9], 32'd0);

    // Round 4: 16th accept lands on the last timer cycle; mask-full wins.
    start_round(32'd7);
    for (int k = 1; k <= 48; k++) step();
    check("r4_rv_idle_wait", {31'd0, round_valid}, 32'd0);
    for (int p = 0; p < 16; p++) accept(p, 32'(p + 500));
    check("r4_round_valid", {31'd0, round_valid}, 32'd1);
    check("r4_timed_out", {31'd0, timed_out}, 32'd0);
    check("r4_mask", {16'd0, mask}, 32'hFFFF);
    check("r4_num16", num[15], 32'd515);
    ack();
    check("r4_count", {24'd0, round_count}, 32'd1);

    // Round counter wrap: 255 more rounds take the count 1 -> 255 -> 0.
    for (int r = 0; r < 254; r++) full_round(32'(r));
    check("wrap_255", {24'd0, round_count}, 32'd255);
    full_round(32'd1);
    check("wrap_0", {24'd0, round_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
